lwe_decrypt_stream: RTL and testbench
=====================================

# lwe_decrypt_stream

Streaming, parametrised LWE decryption engine for the enclave datapath. It holds a DIMENSION-entry secret key and accepts ciphertexts one element per beat: DIMENSION `a` elements followed by `b`. It accumulates the inner product `<a,s>` mod q and emits the rounded plaintext `round((b - <a,s>) * p / q) mod p` through a buffered valid/ready output. It supersedes the single-shot combinational decrypt and adds arbitrary dimension, key loading, backpressure and an optional noise-margin check.

## Interface
- PLAINTEXT_WIDTH, 6, log2 of plaintext modulus p; PLAINTEXT_MODULUS = 2**PLAINTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 10, log2 of ciphertext modulus q; CIPHERTEXT_MODULUS = 2**CIPHERTEXT_WIDTH; must exceed PLAINTEXT_WIDTH+1.
- DIMENSION, 4, LWE dimension n (number of `a` elements and key entries), >= 1.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_we  input  1  secret-key write strobe.
- key_addr  input  $clog2(DIMENSION) (min 1)  key entry index.
- key_data  input  CIPHERTEXT_WIDTH  key entry value.
- key_ready  output  1  high when a key write will be accepted.
- ct_valid  input  1  ciphertext beat valid.
- ct_ready  output  1  ciphertext beat accepted when valid && ready.
- ct_data  input  CIPHERTEXT_WIDTH  element: `a[0..n-1]`, then `b`.
- pt_valid  output  1  plaintext available.
- pt_ready  input  1  downstream accepts plaintext.
- pt_data  output  PLAINTEXT_WIDTH  decrypted plaintext.
- pt_noise  output  1  noise-margin flag (NOISE_CHECK_EN only; tied 0 otherwise).

## Operation
- Beat counter `idx` runs 0..DIMENSION; states ACC (idx < DIMENSION) and FIN (idx == DIMENSION).
- ACC beat: `acc <= (acc + ct_data * key[idx]) mod q`; product is 2*CW bits and only its low CW bits are kept; idx++.
- FIN beat (`b`): `diff = (b - acc) mod q` (CW bits); `pt = ((diff + 2**(CW-PW-1)) >> (CW-PW)) mod p`, with the add done in CW+1 bits so the carry wraps (diff near q rounds to 0). Result loads the output register and sets pt_valid; acc and idx clear to 0.
- ct_ready = 1 in ACC; in FIN, ct_ready = !pt_valid || pt_ready, which gives a single-entry buffer with no bubble.
- pt_valid clears on pt_valid && pt_ready unless a FIN beat reloads it in the same cycle. In that case it stays 1 with the new data.
- key_ready = (idx == 0). Key writes while idx != 0 are ignored. A key write and an idx-0 beat in the same cycle: the beat uses the old key[0], and the write lands at the clock edge.
- Out-of-range key_addr (>= DIMENSION) is ignored.

## Timing
- Reset (async, any time, including mid-ciphertext): idx=0, acc=0, all key entries=0, pt_valid=0, pt_data=0, pt_noise=0. A partial ciphertext is discarded.
- Throughput: one ciphertext per DIMENSION+1 accepted beats; gaps in ct_valid are allowed.
- Latency: pt_valid rises the cycle after the FIN beat is accepted.
- pt_data and pt_noise are registered and stable while pt_valid && !pt_ready.

## Configuration
- NOISE_CHECK_EN defined: compute signed residual `e = diff - (pt << (CW-PW))` (CW-bit two's complement). pt_noise is registered with pt_data and is 1 when |e| >= q/(4p), i.e. 2**(CW-PW-2). This adds one comparator and no extra latency.
- NOISE_CHECK_EN undefined: no residual logic; pt_noise is constant 0.

## Structure
- Package lwe_pkg holds the state typedef (ACC, FIN) and the functions/localparams SCALE_SHIFT = CW-PW, ROUND_HALF = 2**(SCALE_SHIFT-1) and NOISE_BOUND = 2**(SCALE_SHIFT-2).
- Sub-module lwe_mac_mod: a combinational CW-bit multiply-accumulate mod 2**CW, instantiated once. The key register file, counter, FSM and output buffer stay in the top.

## Test plan
- CW=10, PW=6, n=1, key[0]=3, beats a=5, b=127, pt_ready=1 -> pt_data=7, pt_noise=0, pt_valid high for one cycle.
- Same key, a=5, b=132 (NOISE_CHECK_EN) -> pt_data=7, pt_noise=1 (e=5 >= 4); with the macro off, pt_noise=0.
- Wrap-around: key[0]=1, a=0, b=1016 -> pt_data=0; key[0]=1, a=1, b=0 (diff=1023) -> pt_data=0.
- Backpressure: n=4, two back-to-back ciphertexts with pt_ready=0 -> first result held; ct_ready=0 on the second `b`. Raising pt_ready accepts the first result, and the second loads in the same cycle with no loss.
- Key gating: a key_we to addr 0 after the first `a` beat is accepted -> ignored and key_ready=0; a write at idx 0 together with a beat -> the beat uses the old key, and the next ciphertext uses the new one.
- Reset asserted after two of four `a` beats -> idx/acc cleared and pt_valid=0; a fresh full ciphertext then decrypts correctly with key=0 (pt equals rounded b).

Source files
------------

// File: rtl/lwe_pkg.sv
// Shared types and scaling helpers for the streaming LWE decrypt engine.
package lwe_pkg;

    // ACC while collecting a[] elements, FIN while waiting for b
    typedef enum logic {
        ACC = 1'b0,
        FIN = 1'b1
    } lwe_state_e;

    // Right shift that maps a value mod q onto the plaintext grid
    function automatic int scale_shift(input int cw, input int pw);
        return cw - pw;
    endfunction

    // Half a plaintext step, added before the shift to round to nearest
    function automatic int round_half(input int cw, input int pw);
        return 1 << (cw - pw - 1);
    endfunction

    // q/(4p): residual magnitude at which the noise flag raises
    function automatic int noise_bound(input int cw, input int pw);
        return 1 << (cw - pw - 2);
    endfunction

    // Values for the default widths (CW=10, PW=6)
    localparam int SCALE_SHIFT = scale_shift(10, 6);
    localparam int ROUND_HALF  = round_half(10, 6);
    localparam int NOISE_BOUND = noise_bound(10, 6);

endpackage

// File: rtl/lwe_mac_mod.sv
// Combinational multiply-accumulate mod 2**CW.
module lwe_mac_mod #(
    parameter int CW = 10
) (
    input  logic [CW-1:0] i_acc,
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_s,
    output logic [CW-1:0] o_acc
);

    // Only the low CW bits of the full product survive the modulus, so the
    // multiply is evaluated directly at CW bits.
    always_comb begin
        o_acc = i_acc + i_a * i_s;
    end

endmodule

// File: rtl/lwe_decrypt_stream.sv
// Streaming LWE decryption: a[0..n-1] then b per ciphertext, one beat each,
// result through a single-entry valid/ready output register.
// Optional feature: define NOISE_CHECK_EN to drive pt_noise from the
// rounding residual; otherwise pt_noise is constant 0.
import lwe_pkg::*;

module lwe_decrypt_stream #(
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 4,
    localparam int AW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_we,
    input  logic [AW-1:0]               key_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0] key_data,
    output logic                        key_ready,
    input  logic                        ct_valid,
    output logic                        ct_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic                        pt_valid,
    input  logic                        pt_ready,
    output logic [PLAINTEXT_WIDTH-1:0]  pt_data,
    output logic                        pt_noise
);

    localparam int CW = CIPHERTEXT_WIDTH;
    localparam int PW = PLAINTEXT_WIDTH;
    localparam int IW = $clog2(DIMENSION + 1);
    localparam int SS = scale_shift(CW, PW);
    localparam logic [CW:0]   RH   = (CW+1)'(round_half(CW, PW));
    localparam logic [IW-1:0] LAST = IW'(DIMENSION - 1);

    logic [CW-1:0] r_key [DIMENSION];
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_acc;
    lwe_state_e    r_state;
    logic          r_pt_valid;
    logic [PW-1:0] r_pt_data;

    lwe_state_e    w_state_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [CW-1:0] w_acc_nxt;
    logic [CW-1:0] w_key_sel;
    logic [CW-1:0] w_mac;
    logic          w_beat;
    logic          w_fin_beat;
    logic          w_key_wr;
    logic [CW-1:0] w_diff;
    logic [CW:0]   w_sum;
    logic [PW-1:0] w_pt;

    assign key_ready  = (r_idx == '0);
    assign ct_ready   = (r_state == ACC) || !r_pt_valid || pt_ready;
    assign w_beat     = ct_valid && ct_ready;
    assign w_fin_beat = w_beat && (r_state == FIN);
    assign w_key_wr   = key_we && key_ready && (int'(key_addr) < DIMENSION);

    // Rounding: the add runs at CW+1 bits so a diff near q carries out and wraps to 0
    assign w_diff = ct_data - r_acc;
    assign w_sum  = {1'b0, w_diff} + RH;
    assign w_pt   = PW'(w_sum >> SS);

    // Key entry for the current beat; FIN has no key and selects 0
    always_comb begin
        w_key_sel = '0;
        for (int i = 0; i < DIMENSION; i++)
            if (r_idx == IW'(i)) w_key_sel = r_key[i];
    end

    lwe_mac_mod #(.CW(CW)) u_mac (
        .i_acc (r_acc),
        .i_a   (ct_data),
        .i_s   (w_key_sel),
        .o_acc (w_mac)
    );

    // Next state: accumulate a[] in ACC, consume b in FIN and restart
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        case (r_state)
            ACC: if (w_beat) begin
                w_acc_nxt = w_mac;
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == LAST) w_state_nxt = FIN;
            end
            FIN: if (w_beat) begin
                w_acc_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ACC;
            end
            default: w_state_nxt = ACC;
        endcase
    end

    // State, beat counter and accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Key file; writes only between ciphertexts so a running sum sees one key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIMENSION; i++) r_key[i] <= '0;
        end else begin
            for (int i = 0; i < DIMENSION; i++)
                if (w_key_wr && key_addr == AW'(i)) r_key[i] <= key_data;
        end
    end

    // Output buffer: a FIN beat reloads, otherwise a handshake drains it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
        end else if (w_fin_beat) begin
            r_pt_valid <= 1'b1;
            r_pt_data  <= w_pt;
        end else if (pt_ready) begin
            r_pt_valid <= 1'b0;
        end
    end

    assign pt_valid = r_pt_valid;
    assign pt_data  = r_pt_data;

`ifdef NOISE_CHECK_EN
    logic [CW-1:0] w_resid;
    logic [CW-1:0] w_resid_abs;
    logic          w_noise;
    logic          r_pt_noise;

    assign w_resid     = w_diff - {w_pt, {SS{1'b0}}};
    assign w_resid_abs = w_resid[CW-1] ? (~w_resid + 1'b1) : w_resid;
    assign w_noise     = (w_resid_abs >= CW'(noise_bound(CW, PW)));

    // Noise flag travels with the plaintext it describes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_pt_noise <= 1'b0;
        else if (w_fin_beat) r_pt_noise <= w_noise;
    end

    assign pt_noise = r_pt_noise;
`else
    assign pt_noise = 1'b0;
`endif

endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// Directed bench for lwe_decrypt_stream (CW=10, PW=6, n=4).
module tb_lwe_decrypt_stream;

    localparam int N = 4;
`ifdef NOISE_CHECK_EN
    localparam int NE = 1;
`else
    localparam int NE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_we;
    logic [1:0] key_addr;
    logic [9:0] key_data;
    logic       key_ready;
    logic       ct_valid;
    logic       ct_ready;
    logic [9:0] ct_data;
    logic       pt_valid;
    logic       pt_ready;
    logic [5:0] pt_data;
    logic       pt_noise;

    int n_tests = 0;
    int n_fail  = 0;

    lwe_decrypt_stream #(
        .PLAINTEXT_WIDTH  (6),
        .CIPHERTEXT_WIDTH (10),
        .DIMENSION        (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .key_ready (key_ready),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_data   (ct_data),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_data   (pt_data),
        .pt_noise  (pt_noise)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_key(input int a, input int d);
        key_we = 1'b1; key_addr = 2'(a); key_data = 10'(d);
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic send_beat(input int d);
        int n;
        n = 0;
        ct_valid = 1'b1; ct_data = 10'(d);
        while (!ct_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!ct_ready) chk("beat_timeout", 0, 1);
        @(posedge clk); #1;
        ct_valid = 1'b0;
    endtask

    task automatic send_ct(input int a0, a1, a2, a3, b);
        send_beat(a0); send_beat(a1); send_beat(a2); send_beat(a3); send_beat(b);
    endtask

    initial begin
        rst = 1'b1; key_we = 0; key_addr = 0; key_data = 0;
        ct_valid = 0; ct_data = 0; pt_ready = 1'b1;
        #22 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_pt_valid", pt_valid, 0);
        chk("rst_pt_data", pt_data, 0);
        chk("rst_pt_noise", pt_noise, 0);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_ct_ready", ct_ready, 1);

        // key[0]=3, a=5, b=127: diff 112 -> 7, residual 0
        write_key(0, 3);
        send_ct(5, 0, 0, 0, 127);
        chk("basic_valid", pt_valid, 1);
        chk("basic_data", pt_data, 7);
        chk("basic_noise", pt_noise, 0);
        @(posedge clk); #1;
        chk("basic_one_cycle", pt_valid, 0);

        // b=132: diff 117 -> 7, residual 5 >= 4
        send_ct(5, 0, 0, 0, 132);
        chk("noise_data", pt_data, 7);
        chk("noise_flag", pt_noise, NE);

        // Wrap-around: diff 1016 rounds past q to 0 (residual -8)
        write_key(0, 1);
        send_ct(0, 0, 0, 0, 1016);
        chk("wrap_hi_data", pt_data, 0);
        chk("wrap_hi_noise", pt_noise, NE);
        // diff 1023 (residual -1)
        send_ct(1, 0, 0, 0, 0);
        chk("wrap_m1_data", pt_data, 0);
        chk("wrap_m1_noise", pt_noise, 0);

        // Backpressure: key 1,2,3,4; ct1 acc=300 b=380 -> 5; ct2 acc=10 b=154 -> 9
        @(posedge clk); #1;
        write_key(1, 2); write_key(2, 3); write_key(3, 4);
        pt_ready = 1'b0;
        send_ct(10, 20, 30, 40, 380);
        chk("bp_first_valid", pt_valid, 1);
        chk("bp_first_data", pt_data, 5);
        send_beat(1); send_beat(1); send_beat(1); send_beat(1);
        ct_valid = 1'b1; ct_data = 10'd154; #1;
        chk("bp_b_stalled", ct_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_stalled", ct_ready, 0);
        chk("bp_held_valid", pt_valid, 1);
        chk("bp_held_data", pt_data, 5);
        pt_ready = 1'b1; #1;
        chk("bp_released", ct_ready, 1);
        @(posedge clk); #1;
        ct_valid = 1'b0;
        chk("bp_reload_valid", pt_valid, 1);
        chk("bp_reload_data", pt_data, 9);
        @(posedge clk); #1;
        chk("bp_drained", pt_valid, 0);

        // Key gating: key = 2,0,0,0; write of 7 mid-ciphertext must be ignored
        write_key(1, 0); write_key(2, 0); write_key(3, 0); write_key(0, 2);
        send_beat(5);
        chk("gate_key_ready", key_ready, 0);
        write_key(0, 7);
        send_beat(0); send_beat(0); send_beat(0); send_beat(58);
        chk("gate_ignored", pt_data, 3);
        // Write of 6 alongside the idx-0 beat: beat still sees key 2
        key_we = 1'b1; key_addr = 2'd0; key_data = 10'd6;
        ct_valid = 1'b1; ct_data = 10'd5;
        #1;
        chk("gate_same_cycle_ready", key_ready, 1);
        @(posedge clk); #1;
        key_we = 1'b0; ct_valid = 1'b0;
        send_beat(0); send_beat(0); send_beat(0); send_beat(58);
        chk("gate_old_key", pt_data, 3);
        // Next ciphertext uses key 6: acc 30, b=78 -> 3 (key 2 would give 4)
        send_ct(5, 0, 0, 0, 78);
        chk("gate_new_key", pt_data, 3);

        // Reset mid-ciphertext with a pending result
        pt_ready = 1'b0;
        send_beat(5); send_beat(5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_key_ready", key_ready, 1);
        chk("mid_rst_pt_valid", pt_valid, 0);
        chk("mid_rst_pt_data", pt_data, 0);
        #2 rst = 1'b0;
        pt_ready = 1'b1;
        @(posedge clk); #1;
        // Keys are now 0, so pt = round(200/16) = 13
        send_ct(9, 9, 9, 9, 200);
        chk("post_rst_valid", pt_valid, 1);
        chk("post_rst_data", pt_data, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
